// File: rtl/alu_seq_ctrl_if.sv
// Bundle between alu_seq_ctrl, its requester and the single external 74181 slice.
// Optional ALU_SEQ_ACC_EN adds the acc_sel request bit.
interface alu_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // Request side
    logic         ena;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cn;
`ifdef ALU_SEQ_ACC_EN
    logic         acc_sel;
`endif

    // Completion side
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         equal;

    // External 74181 slice
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cn;
    logic [3:0]   alu_f;
    logic         alu_cn4;
    logic         alu_equal;

    // Environment: requester plus the combinational slice
    modport master (
        output ena, start, op_a, op_b, op_s, op_m, op_cn,
`ifdef ALU_SEQ_ACC_EN
        output acc_sel,
`endif
        input  busy, done, result, cout, equal,
        input  alu_a, alu_b, alu_s, alu_m, alu_cn,
        output alu_f, alu_cn4, alu_equal
    );

    // Sequencer
    modport slave (
        input  ena, start, op_a, op_b, op_s, op_m, op_cn,
`ifdef ALU_SEQ_ACC_EN
        input  acc_sel,
`endif
        output busy, done, result, cout, equal,
        output alu_a, alu_b, alu_s, alu_m, alu_cn,
        input  alu_f, alu_cn4, alu_equal
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Runs a W-bit 74181 operation through one external 4-bit slice, one nibble per cycle.
// Define ALU_SEQ_ACC_EN to let acc_sel reuse the previous result as operand A.
module alu_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_seq_ctrl_if.slave bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;
    logic [3:0]       s_q,      s_d;
    logic             m_q,      m_d;
    logic             cn_q,     cn_d;
    logic             carry_q,  carry_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;
    logic             equal_q,  equal_d;

    logic [W-1:0]     a_sel;

`ifdef ALU_SEQ_ACC_EN
    // result_q still holds the previous operation here; it is cleared on the same edge.
    assign a_sel = bus.acc_sel ? result_q : bus.op_a;
`else
    assign a_sel = bus.op_a;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a value unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        cn_d     = cn_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        equal_d  = equal_q;

        if (bus.ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_d      = a_sel;
                        b_d      = bus.op_b;
                        s_d      = bus.op_s;
                        m_d      = bus.op_m;
                        cn_d     = bus.op_cn;
                        result_d = '0;
                        equal_d  = 1'b1;
                        idx_d    = '0;
                        state_d  = S_RUN;
                    end
                end
                S_RUN: begin
                    result_d[{idx_q, 2'b00} +: 4] = bus.alu_f;
                    carry_d = bus.alu_cn4;
                    equal_d = equal_q & bus.alu_equal;
                    if (idx_q == LAST_IDX) begin
                        cout_d  = bus.alu_cn4;
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Slice drive depends only on registered state, never on the slice's own returns.
    always_comb begin
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_s  = '0;
        bus.alu_m  = 1'b0;
        bus.alu_cn = 1'b0;
        if (state_q == S_RUN) begin
            bus.alu_a  = a_q[{idx_q, 2'b00} +: 4];
            bus.alu_b  = b_q[{idx_q, 2'b00} +: 4];
            bus.alu_s  = s_q;
            bus.alu_m  = m_q;
            bus.alu_cn = (idx_q == '0) ? cn_q : carry_q;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.equal  = equal_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            cn_q     <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            equal_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            cn_q     <= cn_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            equal_q  <= equal_d;
        end
    end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices sequenced per operation; operand width W = 4*NIBBLES.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ena  in  1  design enable; when 0, all state holds.
REQ-005 start  in  1  request to begin an operation; sampled in IDLE only.
REQ-006 op_a, op_b  in  W  operands.
REQ-007 op_s  in  4  74181 function select; op_m  in  1  mode (1=logic); op_cn  in  1  carry-in to slice 0, 74181 polarity.
REQ-008 busy  out  1  high while an operation is in flight.
REQ-009 done  out  1  one-cycle pulse when result is valid.
REQ-010 result  out  W  assembled F; cout  out  1  last slice Cn+4; equal  out  1  AND of all slice A=B outputs.
REQ-011 alu_a, alu_b  out  4  nibble operands to the single external 74181 slice; alu_s  out  4; alu_m  out  1; alu_cn  out  1.
REQ-012 alu_f  in  4; alu_cn4  in  1; alu_equal  in  1  combinational returns from that slice.

Function
REQ-013 States: IDLE, RUN, DONE; nibble counter idx of width ceil(log2(NIBBLES)), minimum 1 bit.
REQ-014 IDLE & ena & start: latch op_a/op_b/op_s/op_m/op_cn, clear result, set equal accumulator to 1, idx=0, go to RUN; busy=1 from the next cycle.
REQ-015 RUN: alu_a/alu_b = latched nibble idx, alu_s/alu_m = latched values, alu_cn = op_cn when idx=0, else carry register.
REQ-016 Each RUN cycle with ena=1: result[4*idx+3:4*idx] <= alu_f, carry register <= alu_cn4, equal <= equal & alu_equal, idx++.
REQ-017 After capturing idx=NIBBLES-1: cout <= alu_cn4, go to DONE; operation latency = NIBBLES+1 cycles from start to done.
REQ-018 DONE: done=1, busy=1 for exactly one cycle, then IDLE.
REQ-019 start while busy is ignored; no queuing.
REQ-020 ena=0 in any state freezes state, idx, carry and outputs; done stays high if frozen in DONE.
REQ-021 result, cout, equal hold their values in IDLE until the next accepted start.
REQ-022 alu_* outputs are driven to 0 in IDLE and DONE.
REQ-023 Operand or op_* changes during RUN do not affect the current operation.

Reset
REQ-024 rst_n=0 at any time, including mid-RUN: state=IDLE, idx=0, carry=0, busy=0, done=0, result=0, cout=0, equal=0, alu_*=0; any in-flight operation is discarded.
REQ-025 First start accepted on the first enabled edge after rst_n deasserts.

Configuration
REQ-026 Macro ALU_SEQ_ACC_EN defined: adds input acc_sel (1 bit); acc_sel=1 at an accepted start latches the current result as operand A instead of op_a.
REQ-027 ALU_SEQ_ACC_EN undefined: no acc_sel port; operand A always comes from op_a.

Verification
REQ-028 NIBBLES=4, op_s=1001, op_m=0, op_cn=1, A=1234h, B=0FFFh, start -> done 5 cycles later, result=2233h, cout=1.
REQ-029 op_s=0110, op_m=0, op_cn=1, A=B=BEEFh -> result=FFFFh, equal=1; repeat with B=BEEEh -> equal=0.
REQ-030 op_s=0110, op_m=1, A=F0F0h, B=FF00h -> result=0FF0h; alu_cn is ignored by the slice in logic mode.
REQ-031 Pulse start again on each cycle while busy -> exactly one done pulse; result matches the first operation only.
REQ-032 Assert rst_n=0 at RUN idx=2 -> all outputs 0 immediately; after release, a new operation completes correctly.
REQ-033 With ALU_SEQ_ACC_EN: first op A=0001h+B=0001h gives 0002h; second op acc_sel=1, B=0003h -> result=0005h.
